// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load alignment/extension, HI/LO registers with write-back bypass.
// Optional misaligned-load detection is enabled by defining LOAD_ALIGN_CHECK_EN.
module mem_wb_stage #(
  parameter logic [31:0] HILO_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_load_op,
  input  logic [1:0]  mem_addr_lo,
  input  logic        mem_whilo,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
  input  logic        stall_mem,
  input  logic        stall_wb,
  input  logic        flush,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        wb_adel
);

  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_LW  = 3'b101;

  logic [4:0]  wd_reg;
  logic        wreg_reg;
  logic [31:0] wdata_reg;
  logic        whilo_reg;
  logic [31:0] wb_hi_reg;
  logic [31:0] wb_lo_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        misaligned;
  logic        wreg_next;

  // Big-endian lanes: offset 0 is the most significant byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = mem_wdata[31-8*gi -: 8];
    end
  endgenerate

  always_comb begin
    byte_sel  = lane[mem_addr_lo];
    half_sel  = mem_addr_lo[1] ? mem_wdata[15:0] : mem_wdata[31:16];
    load_data = mem_wdata;
    case (mem_load_op)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0, half_sel};
      default: load_data = mem_wdata;
    endcase
  end

`ifdef LOAD_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if ((mem_load_op == OP_LH || mem_load_op == OP_LHU) && mem_addr_lo[0])
      misaligned = 1'b1;
    else if (mem_load_op == OP_LW && mem_addr_lo != 2'b00)
      misaligned = 1'b1;
  end
`else
  assign misaligned = 1'b0;
`endif

  // A write to r0 is never presented to the register file.
  assign wreg_next = mem_wreg && (mem_wd != 5'd0) && !misaligned;

  always_ff @(posedge clk) begin
    if (rst || flush || (stall_mem && !stall_wb)) begin
      wd_reg    <= 5'd0;
      wreg_reg  <= 1'b0;
      wdata_reg <= 32'h0;
      whilo_reg <= 1'b0;
      wb_hi_reg <= 32'h0;
      wb_lo_reg <= 32'h0;
    end else if (!stall_mem) begin
      wd_reg    <= mem_wd;
      wreg_reg  <= wreg_next;
      wdata_reg <= load_data;
      whilo_reg <= mem_whilo;
      wb_hi_reg <= mem_hi;
      wb_lo_reg <= mem_lo;
    end
  end

`ifdef LOAD_ALIGN_CHECK_EN
  logic adel_reg;
  always_ff @(posedge clk) begin
    if (rst || flush || (stall_mem && !stall_wb))
      adel_reg <= 1'b0;
    else if (!stall_mem)
      adel_reg <= misaligned;
  end
  assign wb_adel = adel_reg;
`else
  assign wb_adel = 1'b0;
`endif

  // Commits even while WB is held; rewriting the same value is harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg <= HILO_RST;
      lo_reg <= HILO_RST;
    end else if (whilo_reg) begin
      hi_reg <= wb_hi_reg;
      lo_reg <= wb_lo_reg;
    end
  end

  assign wb_wd    = wd_reg;
  assign wb_wreg  = wreg_reg;
  assign wb_wdata = wdata_reg;
  assign hi_o     = whilo_reg ? wb_hi_reg : hi_reg;
  assign lo_o     = whilo_reg ? wb_lo_reg : lo_reg;

endmodule
